// File: rtl/sb_io_pad_bank.sv
// sb_io_pad_bank: bank of bidirectional iCE40 pads with synchronised, glitch-filtered inputs
// and registered (optionally open-drain) outputs; pads modelled as SB_IO PIN_TYPE 6'b1010_01.
module sb_io_pad_bank #(
    parameter int               WIDTH         = 8,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] OPEN_DRAIN    = '0,
    parameter logic [WIDTH-1:0] IN_RESET      = '0
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [WIDTH-1:0] pad,
    input  logic [WIDTH-1:0] out_data,
    input  logic [WIDTH-1:0] out_en,
    output logic [WIDTH-1:0] in_level,
    output logic [WIDTH-1:0] in_rise,
    output logic [WIDTH-1:0] in_fall
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s, level_d, oe_q, dout_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Edge pulses are computed from the next level so they line up with the new in_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IN_RESET;
            in_level <= IN_RESET;
            in_rise  <= '0;
            in_fall  <= '0;
            oe_q     <= '0;
            dout_q   <= '0;
        end else begin
            sync_q[0] <= pad;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            in_level <= level_d;
            in_rise  <= level_d & ~in_level;
            in_fall  <= ~level_d & in_level;
            oe_q     <= out_en & (~OPEN_DRAIN | ~out_data);
            dout_q   <= out_data & ~OPEN_DRAIN;
        end
    end

    if (FILTER_CYCLES > 0) begin : g_filt
        localparam int            CW   = $clog2(FILTER_CYCLES + 1);
        localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
        logic [CW-1:0]    cnt_q [WIDTH];
        logic [CW-1:0]    cnt_d [WIDTH];
        logic [WIDTH-1:0] lvl;
        // Any return to the held level drops all accumulated credit.
        always_comb begin
            lvl   = in_level;
            cnt_d = '{default: '0};
            for (int i = 0; i < WIDTH; i++) begin
                lvl[i]   = (sync_s[i] != in_level[i] && cnt_q[i] == LAST) ? sync_s[i] : in_level[i];
                cnt_d[i] = (sync_s[i] != in_level[i] && cnt_q[i] != LAST) ? cnt_q[i] + 1'b1 : '0;
            end
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '{default: '0};
            else     cnt_q <= cnt_d;
        end
        assign level_d = lvl;
    end else begin : g_bypass
        assign level_d = sync_s;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign pad[g] = oe_q[g] ? dout_q[g] : 1'bz;
    end
endmodule

// File: tb/tb_sb_io_pad_bank.sv
// tb_sb_io_pad_bank: directed checks of filtering, bypass, open-drain output and async reset.
module tb_sb_io_pad_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] out_data_a = '0, out_en_a = '0, den_a = '1, dv_a = '0;
    logic [7:0] in_level_a, in_rise_a, in_fall_a;
    logic [3:0] out_data_b = '0, out_en_b = '0, dv_b = '0;
    logic [3:0] in_level_b, in_rise_b, in_fall_b;
    wire  [7:0] pad_a;
    wire  [3:0] pad_b;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_drv_a
        assign pad_a[g] = den_a[g] ? dv_a[g] : 1'bz;
    end
    assign pad_b = dv_b;

    sb_io_pad_bank #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .OPEN_DRAIN(8'h01), .IN_RESET(8'h00)) dut_a (
        .clk(clk), .rst(rst), .pad(pad_a), .out_data(out_data_a), .out_en(out_en_a),
        .in_level(in_level_a), .in_rise(in_rise_a), .in_fall(in_fall_a));

    sb_io_pad_bank #(.WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(0), .OPEN_DRAIN(4'h0), .IN_RESET(4'h0)) dut_b (
        .clk(clk), .rst(rst), .pad(pad_b), .out_data(out_data_b), .out_en(out_en_b),
        .in_level(in_level_b), .in_rise(in_rise_b), .in_fall(in_fall_b));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        // reset with every drive request asserted
        out_en_a = '1;
        out_data_a = '1;
        repeat (3) @(negedge clk);
        chk("rst_oe", 32'(dut_a.oe_q), 32'h0);
        chk("rst_level", 32'(in_level_a), 32'h0);
        chk("rst_edges", 32'({in_rise_a, in_fall_a}), 32'h0);
        chk("rst_level_b", 32'(in_level_b), 32'h0);
        out_en_a = '0;
        out_data_a = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_edges", 32'({in_rise_a, in_fall_a, in_rise_b, in_fall_b}), 32'h0);
        repeat (2) @(negedge clk);

        // clean step on pad[0]: rise then fall, six edges each
        dv_a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("step_lvl_%0d", k), 32'(in_level_a[0]), 32'(k >= 6));
            chk($sformatf("step_rise_%0d", k), 32'(in_rise_a[0]), 32'(k == 6));
        end
        dv_a[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("stepf_lvl_%0d", k), 32'(in_level_a[0]), 32'(k < 6));
            chk($sformatf("stepf_fall_%0d", k), 32'(in_fall_a[0]), 32'(k == 6));
        end

        // 3-cycle glitch on pad[3] is rejected
        dv_a[3] = 1'b1;
        repeat (3) @(negedge clk);
        dv_a[3] = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("glitch_%0d", k), 32'({in_level_a[3], in_rise_a[3], in_fall_a[3]}), 32'h0);
        end
        // 4-cycle pulse on pad[3] is accepted, then its fall too
        dv_a[3] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 4) dv_a[3] = 1'b0;
            chk($sformatf("pulse4_%0d", k), 32'({in_level_a[3], in_rise_a[3], in_fall_a[3]}),
                32'({k >= 6 && k < 10, k == 6, k == 10}));
        end

        // bypass instance: 1-cycle pulse on pad_b[1]
        dv_b[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) dv_b[1] = 1'b0;
            chk($sformatf("bypass_%0d", k), 32'({in_level_b[1], in_rise_b[1], in_fall_b[1]}),
                32'({k == 4, k == 4, k == 5}));
        end

        // open-drain bit 0, push-pull bit 1
        den_a[1:0] = 2'b00;
        out_en_a[1:0] = 2'b11;
        out_data_a[1:0] = 2'b11;
        @(negedge clk);
        chk("od_release", 32'(dut_a.oe_q[0]), 32'h0);
        chk("pp_oe", 32'(dut_a.oe_q[1]), 32'h1);
        chk("pp_high", 32'(pad_a[1]), 32'h1);
        out_data_a[1:0] = 2'b00;
        @(negedge clk);
        chk("od_oe_low", 32'({dut_a.oe_q[0], dut_a.dout_q[0]}), 32'h2);
        chk("od_pad_low", 32'(pad_a[0]), 32'h0);
        chk("pp_low", 32'(pad_a[1]), 32'h0);
        out_en_a[0] = 1'b0;
        @(negedge clk);
        chk("od_en_off", 32'(dut_a.oe_q[0]), 32'h0);
        repeat (8) @(negedge clk);
        // loopback: driven bit 1 appears on in_level after 1 + 6 edges
        out_data_a[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k >= 6) chk($sformatf("loop_%0d", k), 32'({in_level_a[1], in_rise_a[1]}), 32'({k == 7, k == 7}));
        end

        // async reset mid-filter on pad[2] while bit 1 is driving
        dv_a[2] = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_oe", 32'(dut_a.oe_q[1]), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_oe", 32'(dut_a.oe_q), 32'h0);
        chk("async_level", 32'(in_level_a), 32'h0);
        chk("async_edges", 32'({in_rise_a, in_fall_a}), 32'h0);
        out_en_a = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("restart_%0d", k), 32'({in_level_a[2], in_rise_a[2], in_fall_a[2]}),
                32'({k >= 6, k == 6, 1'b0}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
